// File: rtl/reg_cmd_ctrl_pkg.sv
// Shared opcodes and FSM encoding for the register command controller.
package reg_cmd_ctrl_pkg;
  localparam logic [7:0] CMD_WR = 8'hAA;
  localparam logic [7:0] CMD_RD = 8'hBB;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_ADDR = 3'd1,
    ST_WR_DATA = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_RD_WAIT = 3'd4,
    ST_TX_SEND = 3'd5
  } state_e;
endpackage

// File: rtl/reg_cmd_ctrl.sv
// Decodes RX write/read frames into register file strobes and forwards
// read data to the TX FIFO. Every output is a flop.
module reg_cmd_ctrl
  import reg_cmd_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ADDR  = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] RX_P_DATA,
  input  logic             RX_D_VLD,
  input  logic [WIDTH-1:0] RdData,
  input  logic             RdData_VLD,
  input  logic             FIFO_FULL,
  output logic             WrEn,
  output logic             RdEn,
  output logic [ADDR-1:0]  Address,
  output logic [WIDTH-1:0] WrData,
  output logic [WIDTH-1:0] TX_P_DATA,
  output logic             TX_D_VLD,
  output logic             BUSY
);

  state_e           state, state_nx;
  logic             wren_nx, rden_nx, txv_nx;
  logic [ADDR-1:0]  addr_nx;
  logic [WIDTH-1:0] wdata_nx, txd_nx;

  always_comb begin
    state_nx = state;
    wren_nx  = 1'b0;
    rden_nx  = 1'b0;
    txv_nx   = 1'b0;
    addr_nx  = Address;
    wdata_nx = WrData;
    txd_nx   = TX_P_DATA;
    case (state)
      ST_IDLE: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == WIDTH'(CMD_WR))      state_nx = ST_WR_ADDR;
          else if (RX_P_DATA == WIDTH'(CMD_RD)) state_nx = ST_RD_ADDR;
        end
      end
      ST_WR_ADDR: begin
        if (RX_D_VLD) begin
          addr_nx  = RX_P_DATA[ADDR-1:0];
          state_nx = ST_WR_DATA;
        end
      end
      ST_WR_DATA: begin
        if (RX_D_VLD) begin
          wdata_nx = RX_P_DATA;
          wren_nx  = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      ST_RD_ADDR: begin
        if (RX_D_VLD) begin
          addr_nx  = RX_P_DATA[ADDR-1:0];
          rden_nx  = 1'b1;
          state_nx = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (RdData_VLD) begin
          txd_nx   = RdData;
          state_nx = ST_TX_SEND;
        end
      end
      ST_TX_SEND: begin
        if (!FIFO_FULL) begin
          txv_nx   = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // BUSY is registered from the next state so it tracks RD_WAIT/TX_SEND exactly.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= ST_IDLE;
      WrEn      <= 1'b0;
      RdEn      <= 1'b0;
      Address   <= '0;
      WrData    <= '0;
      TX_P_DATA <= '0;
      TX_D_VLD  <= 1'b0;
      BUSY      <= 1'b0;
    end else begin
      state     <= state_nx;
      WrEn      <= wren_nx;
      RdEn      <= rden_nx;
      Address   <= addr_nx;
      WrData    <= wdata_nx;
      TX_P_DATA <= txd_nx;
      TX_D_VLD  <= txv_nx;
      BUSY      <= (state_nx == ST_RD_WAIT) || (state_nx == ST_TX_SEND);
    end
  end

endmodule
